// File: rtl/ysyx_halt_pkg.sv
// Shared types and default constants for the simulation-halt sequencer.
package ysyx_halt_pkg;

  localparam int XLEN          = 64;
  localparam int SETTLE_DEF    = 2;
  localparam int DRAIN_MAX_DEF = 64;
  localparam int TO_W_DEF      = 8;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } halt_state_e;

endpackage

// File: rtl/ysyx_halt_perf_cnt.sv
// Cycle and retired-instruction counters for the halt sequencer.
// Only compiled and instantiated when YSYX_HALT_PERF_EN is defined.
`ifdef YSYX_HALT_PERF_EN
module ysyx_halt_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc_inc_i,
  input  logic        ret_inc_i,
  input  logic        freeze_i,
  output logic [63:0] cycle_cnt_o,
  output logic [63:0] instret_cnt_o
);

  logic [63:0] cycle_q, cycle_d;
  logic [63:0] instret_q, instret_d;

  // Next counter values; both hold once the core has halted and wrap naturally.
  always_comb begin
    cycle_d   = cycle_q;
    instret_d = instret_q;
    if (!freeze_i && cyc_inc_i) cycle_d   = cycle_q + 64'd1;
    if (!freeze_i && ret_inc_i) instret_d = instret_q + 64'd1;
  end

  // Counter registers, cleared by the active-low asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_cnt_o   = cycle_q;
  assign instret_cnt_o = instret_q;

endmodule
`endif

// File: rtl/ysyx_halt_ctrl.sv
// Simulation-halt sequencer: on a committed ebreak it freezes and flushes the
// pipeline, waits for fetch/LSU to drain (with timeout), then raises a sticky
// halt with the captured exit code and trap PC.
// Optional perf counters are enabled by defining YSYX_HALT_PERF_EN.
module ysyx_halt_ctrl #(
  parameter int XLEN      = ysyx_halt_pkg::XLEN,
  parameter int SETTLE    = ysyx_halt_pkg::SETTLE_DEF,
  parameter int DRAIN_MAX = ysyx_halt_pkg::DRAIN_MAX_DEF,
  parameter int TO_W      = ysyx_halt_pkg::TO_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            commit_valid,
  input  logic            commit_ebreak,
  input  logic [XLEN-1:0] commit_pc,
  input  logic [XLEN-1:0] a0_data,
  input  logic            ifu_busy,
  input  logic            lsu_busy,
  output logic            stall_req,
  output logic            flush_req,
  output logic            halt,
  output logic            good_trap,
  output logic            timeout,
  output logic [XLEN-1:0] exit_code,
  output logic [XLEN-1:0] trap_pc,
  output logic [63:0]     cycle_cnt,
  output logic [63:0]     instret_cnt
);

  import ysyx_halt_pkg::*;

  localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  halt_state_e     state_q;
  logic            stall_q, flush_q, halt_q, good_q, timeout_q;
  logic [XLEN-1:0] exit_q, pc_q;
  logic [SW-1:0]   settle_q;
  logic [TO_W-1:0] to_q;

  logic idle, settleDone, toDone;

  assign idle       = !ifu_busy && !lsu_busy;
  assign settleDone = idle && (settle_q == SW'(SETTLE - 1));
  assign toDone     = (to_q == TO_W'(DRAIN_MAX - 1));

  // Halt sequencer FSM with all outputs registered; settle beats timeout on a tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      stall_q   <= 1'b0;
      flush_q   <= 1'b0;
      halt_q    <= 1'b0;
      good_q    <= 1'b0;
      timeout_q <= 1'b0;
      exit_q    <= '0;
      pc_q      <= '0;
      settle_q  <= '0;
      to_q      <= '0;
    end else begin
      flush_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (commit_valid && commit_ebreak) begin
            state_q  <= DRAIN;
            stall_q  <= 1'b1;
            flush_q  <= 1'b1;
            exit_q   <= a0_data;
            pc_q     <= commit_pc;
            settle_q <= '0;
            to_q     <= '0;
          end
        end
        DRAIN: begin
          to_q     <= to_q + TO_W'(1);
          settle_q <= idle ? settle_q + SW'(1) : '0;
          if (settleDone) begin
            state_q   <= HALTED;
            halt_q    <= 1'b1;
            timeout_q <= 1'b0;
            good_q    <= (exit_q == '0);
          end else if (toDone) begin
            state_q   <= HALTED;
            halt_q    <= 1'b1;
            timeout_q <= 1'b1;
            good_q    <= 1'b0;
          end
        end
        HALTED: begin
          stall_q <= 1'b1;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign stall_req = stall_q;
  assign flush_req = flush_q;
  assign halt      = halt_q;
  assign good_trap = good_q;
  assign timeout   = timeout_q;
  assign exit_code = exit_q;
  assign trap_pc   = pc_q;

`ifdef YSYX_HALT_PERF_EN
  ysyx_halt_perf_cnt u_perf (
    .clk          (clk),
    .rst          (rst),
    .cyc_inc_i    (state_q != HALTED),
    .ret_inc_i    (commit_valid && (state_q == RUN)),
    .freeze_i     (state_q == HALTED),
    .cycle_cnt_o  (cycle_cnt),
    .instret_cnt_o(instret_cnt)
  );
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_halt_ctrl.sv
// Self-checking bench for ysyx_halt_ctrl: table of ebreak scenarios scored
// through an expectation queue, plus hand-written reset and perf sequences.
module tb_ysyx_halt_ctrl;

  localparam int DRAIN_MAX = 64;

  logic        clk;
  logic        rst;
  logic        commit_valid;
  logic        commit_ebreak;
  logic [63:0] commit_pc;
  logic [63:0] a0_data;
  logic        ifu_busy;
  logic        lsu_busy;
  logic        stall_req;
  logic        flush_req;
  logic        halt;
  logic        good_trap;
  logic        timeout;
  logic [63:0] exit_code;
  logic [63:0] trap_pc;
  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [63:0] a0;
    logic [63:0] pc;
    int          busyUntil;
    int          ifuAt;
    bit          stuck;
    int          expLat;
    logic        expTimeout;
    logic        expGood;
  } vec_t;

  typedef struct {
    string       name;
    logic [63:0] exitCode;
    logic [63:0] pc;
    int          lat;
    logic        to;
    logic        good;
  } exp_t;

  vec_t vecs[7];
  exp_t sbQ[$];

  ysyx_halt_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .commit_valid (commit_valid),
    .commit_ebreak(commit_ebreak),
    .commit_pc    (commit_pc),
    .a0_data      (a0_data),
    .ifu_busy     (ifu_busy),
    .lsu_busy     (lsu_busy),
    .stall_req    (stall_req),
    .flush_req    (flush_req),
    .halt         (halt),
    .good_trap    (good_trap),
    .timeout      (timeout),
    .exit_code    (exit_code),
    .trap_pc      (trap_pc),
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    commit_valid  = 1'b0;
    commit_ebreak = 1'b0;
    commit_pc     = '0;
    a0_data       = '0;
    ifu_busy      = 1'b0;
    lsu_busy      = 1'b0;
  endtask

  task automatic resetDut();
    @(negedge clk);
    clearInputs();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic driveEbreak(input logic [63:0] a0, input logic [63:0] pc);
    @(negedge clk);
    commit_valid  = 1'b1;
    commit_ebreak = 1'b1;
    commit_pc     = pc;
    a0_data       = a0;
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    bit   seen;
    int   lat;
    resetDut();
    driveEbreak(v.a0, v.pc);
    e.name = v.name; e.exitCode = v.a0; e.pc = v.pc;
    e.lat = v.expLat; e.to = v.expTimeout; e.good = v.expGood;
    sbQ.push_back(e);
    @(posedge clk); #1;
    checkOutput({v.name, " stall@N+1"}, 64'(stall_req), 64'd1);
    checkOutput({v.name, " flush@N+1"}, 64'(flush_req), 64'd1);
    checkOutput({v.name, " halt@N+1"}, 64'(halt), 64'd0);
    seen = 0;
    lat  = 0;
    for (int c = 1; c <= DRAIN_MAX + 8 && !seen; c++) begin
      @(negedge clk);
      commit_valid  = 1'b0;
      commit_ebreak = 1'b0;
      lsu_busy      = v.stuck || (c <= v.busyUntil);
      ifu_busy      = (c == v.ifuAt);
      @(posedge clk); #1;
      if (c == 1) checkOutput({v.name, " flush@N+2"}, 64'(flush_req), 64'd0);
      if (halt) begin
        seen = 1;
        lat  = c;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s halt wait: no halt within %0d cycles", v.name, DRAIN_MAX + 8);
    end else if (sbQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s scoreboard: halt seen with no expectation queued", v.name);
    end else begin
      e = sbQ.pop_front();
      checkOutput({e.name, " latency"}, 64'(lat), 64'(e.lat));
      checkOutput({e.name, " exit_code"}, exit_code, e.exitCode);
      checkOutput({e.name, " trap_pc"}, trap_pc, e.pc);
      checkOutput({e.name, " good_trap"}, 64'(good_trap), 64'(e.good));
      checkOutput({e.name, " timeout"}, 64'(timeout), 64'(e.to));
      checkOutput({e.name, " stall"}, 64'(stall_req), 64'd1);
    end
    // A later ebreak must not disturb the halted, captured state.
    driveEbreak(~v.a0, v.pc + 64'd4);
    repeat (3) @(posedge clk);
    #1;
    checkOutput({v.name, " sticky halt"}, 64'(halt), 64'd1);
    checkOutput({v.name, " exit held"}, exit_code, v.a0);
    checkOutput({v.name, " pc held"}, trap_pc, v.pc);
    @(negedge clk);
    clearInputs();
  endtask

  task automatic waitHalt(input string name, input int budget);
    bit seen = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(posedge clk); #1;
      if (halt) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: no halt within %0d cycles", name, budget);
    end
  endtask

  initial begin
    vecs[0] = '{"clean",      64'h0,                    64'h8000_0010,         0,  0, 1'b0, 2,  1'b0, 1'b1};
    vecs[1] = '{"bad",        64'h1,                    64'h8000_0010,         0,  0, 1'b0, 2,  1'b0, 1'b0};
    vecs[2] = '{"drain_wait", 64'h0,                    64'h8000_0100,         5,  7, 1'b0, 9,  1'b0, 1'b1};
    vecs[3] = '{"timeout",    64'h0,                    64'h8000_0104,         0,  0, 1'b1, 64, 1'b1, 1'b0};
    vecs[4] = '{"tie",        64'h0,                    64'h8000_0108,         62, 0, 1'b0, 64, 1'b0, 1'b1};
    vecs[5] = '{"just_miss",  64'h123,                  64'h8000_010C,         63, 0, 1'b0, 64, 1'b1, 1'b0};
    vecs[6] = '{"wide",       64'hDEAD_BEEF_0000_0001,  64'hFFFF_FFFF_FFFF_FFF0, 1, 0, 1'b0, 3,  1'b0, 1'b0};

    clearInputs();
    rst = 1'b0;
    #2;
    checkOutput("reset stall", 64'(stall_req), 64'd0);
    checkOutput("reset flush", 64'(flush_req), 64'd0);
    checkOutput("reset halt", 64'(halt), 64'd0);
    checkOutput("reset exit_code", exit_code, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // Asynchronous reset in the middle of a drain, then a fresh trap.
    resetDut();
    driveEbreak(64'h5, 64'h8000_0200);
    @(posedge clk);
    @(negedge clk);
    clearInputs();
    lsu_busy = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async rst stall", 64'(stall_req), 64'd0);
    checkOutput("async rst flush", 64'(flush_req), 64'd0);
    checkOutput("async rst halt", 64'(halt), 64'd0);
    checkOutput("async rst exit_code", exit_code, 64'd0);
    checkOutput("async rst trap_pc", trap_pc, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    lsu_busy = 1'b0;
    commit_ebreak = 1'b1;
    @(posedge clk); #1;
    checkOutput("ebreak w/o valid ignored", 64'(stall_req), 64'd0);
    driveEbreak(64'h77, 64'h8000_0300);
    @(negedge clk);
    clearInputs();
    waitHalt("post-reset trap", 10);
    checkOutput("post-reset exit_code", exit_code, 64'h77);
    checkOutput("post-reset trap_pc", trap_pc, 64'h8000_0300);
    checkOutput("post-reset good_trap", 64'(good_trap), 64'd0);

`ifdef YSYX_HALT_PERF_EN
    begin
      logic [63:0] cycSnap;
      resetDut();
      for (int i = 0; i < 9; i++) begin
        @(negedge clk);
        commit_valid  = 1'b1;
        commit_ebreak = 1'b0;
      end
      driveEbreak(64'h0, 64'h8000_0400);
      @(negedge clk);
      clearInputs();
      waitHalt("perf trap", 10);
      checkOutput("perf instret", instret_cnt, 64'd10);
      cycSnap = cycle_cnt;
      @(negedge clk);
      commit_valid = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("perf instret frozen", instret_cnt, 64'd10);
      checkOutput("perf cycle frozen", cycle_cnt, cycSnap);
      @(negedge clk);
      clearInputs();
    end
`else
    checkOutput("no-perf cycle_cnt", cycle_cnt, 64'd0);
    checkOutput("no-perf instret_cnt", instret_cnt, 64'd0);
`endif

    if (sbQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard drain: %0d expectations left, expected 0", sbQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_halt_ctrl.md
Name: ysyx_halt_ctrl

Overview:
- Simulation-halt sequencer for the RV64 core. It sits between the commit/WB stage and the simulation environment.
- On a committed ebreak it freezes the pipeline and waits for the fetch and LSU interfaces to drain.
- It then asserts a sticky halt with the exit code (a0) and the trap PC.
- It replaces the bare fixed-delay ebreak path with a handshake-aware, timeout-protected controller.

Parameters:
- XLEN, 64, datapath width of a0 and the PC.
- SETTLE, 2, number of consecutive idle cycles (ifu_busy=0 and lsu_busy=0) required before halting.
- DRAIN_MAX, 64, timeout in cycles for the DRAIN state.
- TO_W, 8, width of the drain timeout counter; must satisfy 2^TO_W > DRAIN_MAX.

Ports:
- clk, input, 1, core clock.
- rst, input, 1, asynchronous active-low reset.
- commit_valid, input, 1, an instruction retires this cycle.
- commit_ebreak, input, 1, the retiring instruction is ebreak; only meaningful when commit_valid=1.
- commit_pc, input, XLEN, PC of the retiring instruction.
- a0_data, input, XLEN, current x10 value, already including this cycle's writeback forwarding.
- ifu_busy, input, 1, the fetch unit has an outstanding bus transaction.
- lsu_busy, input, 1, the LSU has an outstanding bus transaction.
- stall_req, output, 1, freezes PC update and all pipeline registers.
- flush_req, output, 1, one-cycle pulse that kills the younger in-flight instructions.
- halt, output, 1, sticky; the simulation is finished.
- good_trap, output, 1, valid when halt=1: exit_code==0 and no timeout.
- timeout, output, 1, valid when halt=1: the drain did not complete within DRAIN_MAX cycles.
- exit_code, output, XLEN, captured a0.
- trap_pc, output, XLEN, captured ebreak PC.
- cycle_cnt, output, 64, performance cycle count (see Optional Feature).
- instret_cnt, output, 64, retired-instruction count (see Optional Feature).

Behaviour:
- Reset: rst=0 asynchronously forces the following, from any state, including mid-DRAIN:
  - state=RUN.
  - All outputs 0.
  - Timeout and settle counters cleared.
  - Captured registers cleared.
- States: RUN, DRAIN, HALTED.
- RUN:
  - On commit_valid & commit_ebreak at edge N: capture exit_code<=a0_data and trap_pc<=commit_pc.
  - At that same edge go to DRAIN, register stall_req<=1 and pulse flush_req<=1. Both are visible from cycle N+1.
  - flush_req stays high for exactly one cycle.
  - commit_ebreak with commit_valid=0 is ignored.
- DRAIN:
  - stall_req is held at 1.
  - The settle counter increments on cycles where ifu_busy=0 and lsu_busy=0, and clears to 0 on any busy cycle.
  - When settle reaches SETTLE, go to HALTED. Minimum ebreak-to-halt latency is SETTLE+1 cycles, i.e. halt is high from cycle N+1+SETTLE.
  - The timeout counter increments every DRAIN cycle. On reaching DRAIN_MAX with the settle condition still unmet, go to HALTED with timeout<=1.
  - If settle completes on the same cycle the timeout expires, settle wins and timeout=0.
  - Further commit_ebreak inputs are ignored. exit_code and trap_pc never change after capture.
- HALTED:
  - halt=1, stall_req=1, absorbing until reset.
  - good_trap = (exit_code==0) & ~timeout, registered on entry.
  - All inputs are ignored.
- Outputs halt, good_trap and timeout are registered (no combinational input-to-output paths). stall_req and flush_req are registered as well.

Optional Feature:
- Macro: YSYX_HALT_PERF_EN.
- With the macro defined:
  - cycle_cnt increments every cycle while state!=HALTED.
  - instret_cnt increments on each commit_valid while in RUN; the ebreak counts as retired.
  - Both counters freeze in HALTED, are cleared by reset, and wrap modulo 2^64.
- Without the macro: cycle_cnt and instret_cnt are tied to 0 and no counter flops are inferred. The port list is unchanged.

Decomposition:
- Shared package ysyx_halt_pkg holds:
  - the state enum (RUN=2'd0, DRAIN=2'd1, HALTED=2'd2);
  - the SETTLE and DRAIN_MAX defaults;
  - the XLEN constant.
- Sub-module ysyx_halt_perf_cnt contains the two 64-bit counters with inc/freeze inputs. It is instantiated only under YSYX_HALT_PERF_EN.

Test Plan:
- Clean trap:
  - Stimulus: a0=0, commit ebreak at PC 0x8000_0010, ifu_busy=lsu_busy=0.
  - Response: stall_req and flush_req high from cycle N+1, flush_req low at N+2, halt=1 from N+3, good_trap=1, trap_pc=0x8000_0010.
- Bad trap:
  - Stimulus: a0=0x1 with otherwise identical stimulus.
  - Response: halt=1, good_trap=0, exit_code=1, timeout=0.
- Drain wait:
  - Stimulus: lsu_busy=1 for 5 cycles after the ebreak, with ifu_busy toggling once mid-settle.
  - Response: the settle counter restarts; halt asserts exactly SETTLE cycles after the last busy cycle.
- Timeout:
  - Stimulus: lsu_busy stuck at 1.
  - Response: halt=1 after DRAIN_MAX cycles in DRAIN, timeout=1, good_trap=0 even though a0=0.
- Reset mid-DRAIN:
  - Stimulus: assert rst=0 asynchronously two cycles after the ebreak.
  - Response: all outputs are 0 immediately, without waiting for a clock edge, and the state is RUN. A second ebreak after reset captures its own a0.
- Perf (YSYX_HALT_PERF_EN defined):
  - Stimulus: 10 commits with the ebreak as the 10th.
  - Response: instret_cnt=10, and both counters are frozen after halt.
